// File: rtl/reg_write_queue.sv
// reg_write_queue: valid/ready buffered feeder for a single-write register.
// Words are queued in a DEPTH-entry FIFO and drained at most one per clock
// onto registered write_data/write_enable.
// Optional feature: define REG_WRITE_COUNT_EN to add a saturating 16-bit
// write_count output that counts write_enable pulses.
module reg_write_queue #(
    parameter int unsigned width = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             drain_hold,
    output logic [width-1:0] write_data,
    output logic             write_enable,
    output logic [AW:0]      level
`ifdef REG_WRITE_COUNT_EN
    ,
    output logic [15:0]      write_count
`endif
);

    logic [width-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic [width-1:0] write_data_q;
    logic             write_enable_q;
    logic             empty, full, push, pop;

    // Flags and handshake derived from the registered occupancy only.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == (AW+1)'(DEPTH));
        in_ready = reset & ~full;
        push     = in_valid & in_ready;
        // Pop sees only pre-edge contents, so an empty queue never falls through.
        pop      = ~empty & ~drain_hold;
    end

    // Occupancy next state: push and pop together leave it unchanged.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array is intentionally not reset; stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                write_data_q   <= mem[rd_ptr_q];
                write_enable_q <= 1'b1;
                rd_ptr_q       <= rd_ptr_q + AW'(1);
            end else begin
                write_enable_q <= 1'b0;
            end
        end
    end

    assign write_data   = write_data_q;
    assign write_enable = write_enable_q;
    assign level        = level_q;

`ifdef REG_WRITE_COUNT_EN
    logic [15:0] write_count_q;

    // Saturating count of write_enable pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_count_q <= '0;
        end else if (write_enable_q && (write_count_q != 16'hFFFF)) begin
            write_count_q <= write_count_q + 16'd1;
        end
    end

    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Randomized self-checking bench for reg_write_queue against a queue model.
module tb_reg_write_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        drain_hold;
    logic [15:0] write_data;
    logic        write_enable;
    logic [2:0]  level;
`ifdef REG_WRITE_COUNT_EN
    logic [15:0] write_count;
`endif

    reg_write_queue dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .drain_hold   (drain_hold),
        .write_data   (write_data),
        .write_enable (write_enable),
        .level        (level)
`ifdef REG_WRITE_COUNT_EN
        ,
        .write_count  (write_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of pending words plus the last emitted word.
    int unsigned q[$];
    logic        exp_we;
    logic [15:0] exp_wd;
    int          exp_cnt;
    int          max_level;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("write_enable", 32'(write_enable), 32'(exp_we));
        check_val("write_data", 32'(write_data), 32'(exp_wd));
        check_val("level", 32'(level), 32'(q.size()));
`ifdef REG_WRITE_COUNT_EN
        check_val("write_count", 32'(write_count), 32'(exp_cnt));
`endif
    endtask

    // Called at a falling edge: drive, check in_ready, clock once, update model, check.
    task automatic step(input logic v, input logic [15:0] d, input logic h);
        bit do_push, do_pop;
        in_valid   = v;
        in_data    = d;
        drain_hold = h;
        #1;
        check_val("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        do_push = v && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && !h;
        @(posedge clk);
        if (exp_we && exp_cnt < 16'hFFFF) exp_cnt++;
        exp_we = do_pop;
        if (do_pop) exp_wd = 16'(q.pop_front());
        if (do_push) q.push_back(int'(d));
        if (q.size() > max_level) max_level = q.size();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, h);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        drain_hold = 1'b0;
        exp_we     = 1'b0;
        exp_wd     = '0;
        exp_cnt    = 0;

        // Reset held for two clocks.
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_outputs();
        reset = 1'b1;
        #1;
        check_val("rel_in_ready", 32'(in_ready), 32'd1);

        // Single word.
        step(1'b1, 16'd25, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b0);

        // Fill while held, offer a fifth word, then drain.
        step(1'b1, 16'd10, 1'b1);
        step(1'b1, 16'd20, 1'b1);
        step(1'b1, 16'd30, 1'b1);
        step(1'b1, 16'd40, 1'b1);
        step(1'b1, 16'd50, 1'b1);
        check_val("full_level", 32'(level), 32'd4);
        for (int i = 0; i < 5; i++) step(1'b1, 16'd50, 1'b0);
        idle(3, 1'b0);

        // Continuous stream exercises wrap and concurrent push/pop.
        max_level = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 16'(i), 1'b0);
        idle(3, 1'b0);
        check_val("stream_level_le2", 32'(max_level <= 2), 32'd1);

        // Hold gap with one queued word.
        step(1'b1, 16'd75, 1'b1);
        idle(3, 1'b1);
        idle(2, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 9) < 3));
        end
        idle(6, 1'b0);

        // Asynchronous reset between edges while a pulse is active.
        for (int i = 0; i < 4; i++) step(1'b1, 16'(100 + i), 1'b1);
        step(1'b0, 16'd0, 1'b0);
        check_val("pre_rst_level", 32'(level), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        exp_we  = 1'b0;
        exp_wd  = '0;
        exp_cnt = 0;
        check_val("async_we", 32'(write_enable), 32'd0);
        check_val("async_level", 32'(level), 32'd0);
        check_val("async_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(4, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0);
        idle(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
